hs_sink: RTL and testbench
==========================

Name: hs_sink

Overview:
- Receiving end of the 16-bit valid/ready link driven by the data-source blocks.
- Accepts words into a small FIFO and re-presents them on a downstream valid/ready port.
- Keeps accept, drop and running-sum statistics for bring-up and debug.
- Sits between any valid/ready source and the consumer logic or test monitor.

Parameters:
DW, 16, data width of input and output words
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, 16, width of the acc_cnt and drop_cnt statistics counters
SUM_W, 24, width of the wrap-around data sum

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous active-low reset
data  in  DW  upstream data
valid  in  1  upstream data valid
ready  out  1  sink can accept this cycle
out_data  out  DW  downstream data (FIFO head)
out_valid  out  1  FIFO non-empty
out_ready  in  1  downstream accepts head this cycle
acc_cnt  out  CNT_W  words accepted since reset
drop_cnt  out  CNT_W  cycles with valid=1 and ready=0
sum  out  SUM_W  modulo-2^SUM_W sum of accepted words, zero-extended
seq_err  out  1  sticky ordering error (present only with HS_SINK_SEQCHK_EN)

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous, active-low; all state changes only on posedge clk.
- Reset (rst_n=0 at posedge):
  - FIFO count, read pointer and write pointer become 0.
  - acc_cnt, drop_cnt and sum become 0; seq_err becomes 0.
  - ready therefore reads 1 on the cycle after reset.
  - Reset mid-transfer discards all buffered words; no partial state survives.
- ready: combinational, ready = (count != DEPTH). It depends only on registered count, never on out_ready, so there is no combinational path out_ready -> ready.
- Push: valid & ready at posedge writes data at wr_ptr. Word is visible on out_data no earlier than the next cycle (latency 1).
- Pop: out_valid & out_ready at posedge advances rd_ptr. out_valid = (count != 0); out_data = mem[rd_ptr].
- Count update:
  - push only: +1; pop only: -1.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- Full: count==DEPTH gives ready=0.
  - Push and pop in the same cycle are still impossible here, because ready is already 0.
  - After a pop, ready returns to 1 in the next cycle.
- Empty: count==0 gives out_valid=0. out_data holds the stale mem[rd_ptr] value and is don't-care.
- Pointers: log2(DEPTH) bits, natural wrap from DEPTH-1 to 0.
- Statistics:
  - acc_cnt += 1 on each push.
  - drop_cnt += 1 on each cycle with valid=1 and ready=0. The source does not hold data under back-pressure, so each such cycle is a lost word.
  - sum += data on each push.
  - All three wrap modulo their width; no saturation.
- Upstream valid may assert or deassert in any cycle; no stability rule is imposed on the source.

Optional Feature:
HS_SINK_SEQCHK_EN
- Defined:
  - Track prev (DW bits) and first (1 bit), both cleared on reset.
  - On each push with first=1: if data <= prev, seq_err sets. Exception: prev[DW-1:DW-4]==4'hF and data[DW-1:DW-4]==4'h0 is a legal wrap.
  - Every push then loads prev=data and sets first=1.
  - seq_err is sticky until reset.
- Not defined: seq_err port, prev and first are absent; all other behaviour is identical.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n=0 for 2 cycles, then valid=0.
  - Response: ready=1, out_valid=0; acc_cnt=0, drop_cnt=0, sum=0.
- Fill to full:
  - Stimulus: out_ready=0; valid=1 with data 8,9,10,11,12 on consecutive cycles.
  - Response: words 8..11 accepted; ready=0 from cycle 5; 12 dropped; acc_cnt=4, drop_cnt=1, sum=38.
- Drain:
  - Stimulus: from the full state, out_ready=1, valid=0.
  - Response: out_data=8,9,10,11 on 4 consecutive cycles, then out_valid=0; ready=1 after the first pop.
- Streaming:
  - Stimulus: valid=1 and out_ready=1 continuously, data 24..31.
  - Response: count stays at 1; each word appears one cycle later; drop_cnt unchanged; sum increases by 220.
- Reset mid-operation:
  - Stimulus: FIFO holding 3 words, rst_n=0 for 1 cycle.
  - Response: out_valid=0, acc_cnt=0, sum=0 next cycle.
- With HS_SINK_SEQCHK_EN:
  - Stimulus 1: accept 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001.
  - Response 1: seq_err=0.
  - Stimulus 2: then accept 16'h0001 again.
  - Response 2: seq_err=1 from the next cycle and stays 1.

Source files
------------

// File: rtl/hs_sink_if.sv
// hs_sink_if: upstream valid/ready link plus downstream FIFO-head port of hs_sink.
// master is the side that drives upstream data and consumes the downstream head.
interface hs_sink_if #(
    parameter int DW = 16
);
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output data, valid, out_ready,
        input  ready, out_data, out_valid
    );

    modport slave (
        input  data, valid, out_ready,
        output ready, out_data, out_valid
    );
endinterface

// File: rtl/hs_sink.sv
// hs_sink: valid/ready receive FIFO with accept/drop/sum statistics counters.
// Defining HS_SINK_SEQCHK_EN adds a sticky seq_err flag for non-increasing data.
module hs_sink #(
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16,
    parameter int SUM_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    hs_sink_if.slave         bus,
    output logic [CNT_W-1:0] acc_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [SUM_W-1:0] sum
`ifdef HS_SINK_SEQCHK_EN
    ,
    output logic             seq_err
`endif
);
    localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    // ready looks only at the registered count, never at out_ready
    assign bus.ready     = (count != FULL);
    assign bus.out_valid = (count != '0);
    assign bus.out_data  = mem[rd_ptr];

    assign push = bus.valid & bus.ready;
    assign pop  = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_cnt  <= '0;
            drop_cnt <= '0;
            sum      <= '0;
        end else begin
            if (push) begin
                acc_cnt <= acc_cnt + CNT_W'(1);
                sum     <= sum + SUM_W'(bus.data);
            end
            // the source does not hold data, so every refused cycle loses a word
            if (bus.valid && !bus.ready) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

`ifdef HS_SINK_SEQCHK_EN
    logic [DW-1:0] prev;
    logic          first;
    logic          wrap_ok;

    // top nibble F -> 0 is a counter rollover, not an ordering error
    assign wrap_ok = (prev[DW-1 -: 4] == 4'hF) && (bus.data[DW-1 -: 4] == 4'h0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev    <= '0;
            first   <= 1'b0;
            seq_err <= 1'b0;
        end else if (push) begin
            if (first && (bus.data <= prev) && !wrap_ok) begin
                seq_err <= 1'b1;
            end
            prev  <= bus.data;
            first <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_hs_sink.sv
// tb_hs_sink: randomized and directed checks of hs_sink against a queue-based model.
// Build with HS_SINK_SEQCHK_EN defined to also exercise the sequence checker.
module tb_hs_sink;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] acc_cnt;
    logic [15:0] drop_cnt;
    logic [23:0] sum;
`ifdef HS_SINK_SEQCHK_EN
    logic        seq_err;
`endif

    hs_sink_if #(.DW(16)) bus ();

    hs_sink #(.DW(16), .DEPTH(DEPTH), .CNT_W(16), .SUM_W(24)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .acc_cnt  (acc_cnt),
        .drop_cnt (drop_cnt),
        .sum      (sum)
`ifdef HS_SINK_SEQCHK_EN
        ,
        .seq_err  (seq_err)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // reference model: contents held as a plain queue, stats as integers
    logic [15:0] m_q[$];
    logic [15:0] m_acc;
    logic [15:0] m_drop;
    logic [23:0] m_sum;
    logic [15:0] m_prev;
    bit          m_first;
    bit          m_seq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_acc = 0; m_drop = 0; m_sum = 0;
            m_prev = 0; m_first = 0; m_seq = 0;
        end else begin
            bit can_take;
            can_take = (m_q.size() < DEPTH);
            if (bus.out_ready && m_q.size() > 0) void'(m_q.pop_front());
            if (bus.valid && can_take) begin
                if (m_first && bus.data <= m_prev &&
                    !(m_prev[15:12] == 4'hF && bus.data[15:12] == 4'h0)) m_seq = 1;
                m_prev  = bus.data;
                m_first = 1;
                m_q.push_back(bus.data);
                m_acc = m_acc + 16'd1;
                m_sum = m_sum + {8'h00, bus.data};
            end else if (bus.valid) begin
                m_drop = m_drop + 16'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", {31'd0, bus.ready}, {31'd0, m_q.size() < DEPTH});
            chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_q.size() > 0});
            if (m_q.size() > 0) chk("out_data", {16'd0, bus.out_data}, {16'd0, m_q[0]});
            chk("acc_cnt", {16'd0, acc_cnt}, {16'd0, m_acc});
            chk("drop_cnt", {16'd0, drop_cnt}, {16'd0, m_drop});
            chk("sum", {8'd0, sum}, {8'd0, m_sum});
`ifdef HS_SINK_SEQCHK_EN
            chk("seq_err", {31'd0, seq_err}, {31'd0, m_seq});
`endif
        end
    end

    task automatic cycle(input logic v, input logic [15:0] d, input logic r);
        bus.valid     = v;
        bus.data      = d;
        bus.out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) cycle(1'b0, 16'h0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.valid = 1'b0; bus.data = '0; bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1;
        do_reset(1);

        // reset then idle
        chk("idle ready", {31'd0, bus.ready}, 32'd1);
        chk("idle out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("idle acc", {16'd0, acc_cnt}, 32'd0);
        chk("idle drop", {16'd0, drop_cnt}, 32'd0);
        chk("idle sum", {8'd0, sum}, 32'd0);

        // fill to full
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'(8 + i), 1'b0);
        chk("full ready", {31'd0, bus.ready}, 32'd0);
        cycle(1'b1, 16'd12, 1'b0);
        chk("fill acc", {16'd0, acc_cnt}, 32'd4);
        chk("fill drop", {16'd0, drop_cnt}, 32'd1);
        chk("fill sum", {8'd0, sum}, 32'd38);

        // drain
        for (int i = 0; i < 4; i++) begin
            chk("drain out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("drain out_data", {16'd0, bus.out_data}, 32'(8 + i));
            cycle(1'b0, 16'h0, 1'b1);
            if (i == 0) chk("drain ready", {31'd0, bus.ready}, 32'd1);
        end
        chk("drained out_valid", {31'd0, bus.out_valid}, 32'd0);

        // streaming
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 16'(24 + i), 1'b1);
            chk("stream out_data", {16'd0, bus.out_data}, 32'(24 + i));
            chk("stream ready", {31'd0, bus.ready}, 32'd1);
        end
        chk("stream sum", {8'd0, sum}, 32'd258);
        chk("stream drop", {16'd0, drop_cnt}, 32'd1);
        chk("stream acc", {16'd0, acc_cnt}, 32'd12);
        cycle(1'b0, 16'h0, 1'b1);

        // reset mid-operation
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'(100 + i), 1'b0);
        do_reset(1);
        chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst acc", {16'd0, acc_cnt}, 32'd0);
        chk("rst sum", {8'd0, sum}, 32'd0);
        chk("rst ready", {31'd0, bus.ready}, 32'd1);

        // randomized traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            cycle($urandom_range(0, 9) < 6, 16'($urandom), $urandom_range(0, 3) != 0);
        end
        rst_n = 1'b1;

`ifdef HS_SINK_SEQCHK_EN
        do_reset(1);
        cycle(1'b1, 16'hFFFE, 1'b1);
        cycle(1'b1, 16'hFFFF, 1'b1);
        cycle(1'b1, 16'h0000, 1'b1);
        cycle(1'b1, 16'h0001, 1'b1);
        chk("seq ok", {31'd0, seq_err}, 32'd0);
        cycle(1'b1, 16'h0001, 1'b1);
        chk("seq err", {31'd0, seq_err}, 32'd1);
        cycle(1'b0, 16'h0, 1'b1);
        cycle(1'b1, 16'h7000, 1'b1);
        chk("seq sticky", {31'd0, seq_err}, 32'd1);
`endif

        cycle(1'b0, 16'h0, 1'b0);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
